pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the hold and bubble controls consumed by the pc, if_id, id_ex, ex_mem and mem_wb stage registers. It handles three cases: load-use hazards, taken-branch flushes, and multi-cycle data-memory/MMIO accesses with a timeout watchdog. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_ADDR_WIDTH, 5, width of register-number fields
MEM_TIMEOUT, 16, max MEM_WAIT cycles before declaring a bus error (must be >=2)
CNT_WIDTH, 16, width of stall_count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
id_valid  in  1  ID holds a real instruction (not no-op)
id_rs  in  REG_ADDR_WIDTH  ID source register 1 number
id_rt  in  REG_ADDR_WIDTH  ID source register 2 number
id_rs_used  in  1  ID instruction reads id_rs
id_rt_used  in  1  ID instruction reads id_rt
ex_valid  in  1  EX holds a real instruction
ex_mem_read  in  1  EX instruction is a load
ex_reg_write_enable  in  1  EX instruction writes a register
ex_rd  in  REG_ADDR_WIDTH  EX destination register number
id_branch_taken  in  1  branch/jump in ID redirects pc this cycle
mem_req  in  1  MEM stage issues a memory/MMIO access
mem_ready  in  1  memory completes the access this cycle
pc_hold  out  1  pc register keeps its value
if_hold  out  1  if_id register keeps its contents
id_bubble  out  1  id_ex loads a no-op instead of ID contents
if_flush  out  1  if_id loads a no-op (discard wrong-path fetch)
ex_hold  out  1  id_ex and ex_mem keep their contents
mem_hold  out  1  mem_wb keeps its contents (writeback suppressed)
mem_timeout_err  out  1  sticky bus-timeout flag
stall_count  out  CNT_WIDTH  saturating count of cycles with pc_hold=1

Behaviour:
- State register: RUN, MEM_WAIT, ERROR. A wait counter (ceil(log2(MEM_TIMEOUT)) bits) is active in MEM_WAIT.
- Control outputs (pc_hold..mem_hold) are combinational from state and inputs. All are forced 0 while rst_n=0.
- Reset (rst_n=0 at a clock edge): state=RUN, wait counter=0, mem_timeout_err=0, stall_count=0. Reset mid-MEM_WAIT or in ERROR returns to RUN with no residual holds.
- load_use = id_valid & ex_valid & ex_mem_read & ex_reg_write_enable & (ex_rd!=0) & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
- mem_stall = mem_req & ~mem_ready.
- RUN, priority mem_stall > load_use > branch:
  - mem_stall: pc_hold=if_hold=ex_hold=mem_hold=1, id_bubble=0, if_flush=0; next=MEM_WAIT, counter=1.
  - load_use (no mem_stall): pc_hold=if_hold=id_bubble=1, others 0. This is a one-cycle stall; no state change, and re-detection next cycle resolves naturally.
  - id_branch_taken, no stall: if_flush=1 only.
  - A branch that coincides with load_use or mem_stall produces no flush. The branch is re-evaluated when ID advances.
  - mem_req & mem_ready in the same cycle: no stall.
- MEM_WAIT:
  - mem_ready=1: all outputs 0 this cycle (pipeline advances; a coincident load_use/branch is applied with RUN rules); next=RUN.
  - mem_ready=0, counter < MEM_TIMEOUT-1: all four holds=1, counter++.
  - mem_ready=0, counter = MEM_TIMEOUT-1: holds=1; next=ERROR; mem_timeout_err<=1.
- ERROR: pc_hold=if_hold=ex_hold=mem_hold=1 permanently, id_bubble=if_flush=0, mem_timeout_err=1. Only reset exits.
- stall_count increments on every clock edge where pc_hold=1 and rst_n=1. It saturates at all-ones, with no wrap.
- At most one of id_bubble / if_flush is asserted per cycle. id_bubble implies pc_hold & if_hold.

Test Plan:
- Load-use: EX lw ex_rd=8, ID add id_rs=8 id_rs_used=1 -> exactly 1 cycle pc_hold=if_hold=id_bubble=1; stall_count=1.
- ex_rd=0, or id_rt=8 with id_rt_used=0 -> no stall; all outputs 0.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> holds asserted 3 cycles, deasserted on the ready cycle; state back to RUN; stall_count=3.
- Timeout: mem_req=1, mem_ready=0 for 20 cycles (MEM_TIMEOUT=16) -> mem_timeout_err=1 after cycle 16; holds stay 1; stall_count keeps counting. rst_n=0 for one edge -> all clear.
- Branch: id_branch_taken=1, no hazards -> if_flush=1 for 1 cycle. Same with load_use active -> if_flush=0, id_bubble=1.
- Saturation: CNT_WIDTH=4, hold ERROR for 20 cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// multi-cycle memory waits with a timeout watchdog, and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_rs_used,
    input  logic                      id_rt_used,
    input  logic                      ex_valid,
    input  logic                      ex_mem_read,
    input  logic                      ex_reg_write_enable,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      id_branch_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_hold,
    output logic                      if_hold,
    output logic                      id_bubble,
    output logic                      if_flush,
    output logic                      ex_hold,
    output logic                      mem_hold,
    output logic                      mem_timeout_err,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    logic load_use;
    logic mem_stall;
    logic pc_hold_c, if_hold_c, id_bubble_c, if_flush_c, ex_hold_c, mem_hold_c;

    assign load_use = id_valid & ex_valid & ex_mem_read & ex_reg_write_enable
                    & (ex_rd != '0)
                    & ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));
    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        err_d       = err_q;
        pc_hold_c   = 1'b0;
        if_hold_c   = 1'b0;
        id_bubble_c = 1'b0;
        if_flush_c  = 1'b0;
        ex_hold_c   = 1'b0;
        mem_hold_c  = 1'b0;

        case (state_q)
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    pc_hold_c  = 1'b1;
                    if_hold_c  = 1'b1;
                    ex_hold_c  = 1'b1;
                    mem_hold_c = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    // Access completes: the pipeline advances and ID hazards resolve as in RUN.
                    state_d = ST_RUN;
                    wait_d  = '0;
                    if (load_use) begin
                        pc_hold_c   = 1'b1;
                        if_hold_c   = 1'b1;
                        id_bubble_c = 1'b1;
                    end else if (id_branch_taken) begin
                        if_flush_c = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                pc_hold_c  = 1'b1;
                if_hold_c  = 1'b1;
                ex_hold_c  = 1'b1;
                mem_hold_c = 1'b1;
                err_d      = 1'b1;
            end
            default: begin
                if (mem_stall) begin
                    pc_hold_c  = 1'b1;
                    if_hold_c  = 1'b1;
                    ex_hold_c  = 1'b1;
                    mem_hold_c = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_d     = WAIT_W'(1);
                end else if (load_use) begin
                    pc_hold_c   = 1'b1;
                    if_hold_c   = 1'b1;
                    id_bubble_c = 1'b1;
                end else if (id_branch_taken) begin
                    if_flush_c = 1'b1;
                end
            end
        endcase

        stall_count_d = stall_count_q;
        if (pc_hold_c && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_q        <= '0;
            err_q         <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            err_q         <= err_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Holds are suppressed while reset is asserted so no stage freezes during reset.
    assign pc_hold         = rst_n & pc_hold_c;
    assign if_hold         = rst_n & if_hold_c;
    assign id_bubble       = rst_n & id_bubble_c;
    assign if_flush        = rst_n & if_flush_c;
    assign ex_hold         = rst_n & ex_hold_c;
    assign mem_hold        = rst_n & mem_hold_c;
    assign mem_timeout_err = err_q;
    assign stall_count     = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; a second instance with a 4-bit
// counter shares the stimulus to exercise stall_count saturation.
module tb_pipeline_hazard_controller;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       ex_valid;
    logic       ex_mem_read;
    logic       ex_reg_write_enable;
    logic [4:0] ex_rd;
    logic       id_branch_taken;
    logic       mem_req;
    logic       mem_ready;

    logic        pc_hold, if_hold, id_bubble, if_flush, ex_hold, mem_hold, mem_timeout_err;
    logic [15:0] stall_count;
    logic        s_pc_hold, s_if_hold, s_id_bubble, s_if_flush, s_ex_hold, s_mem_hold, s_err;
    logic [3:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_reg_write_enable(ex_reg_write_enable), .ex_rd(ex_rd),
        .id_branch_taken(id_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_hold(pc_hold), .if_hold(if_hold), .id_bubble(id_bubble), .if_flush(if_flush),
        .ex_hold(ex_hold), .mem_hold(mem_hold), .mem_timeout_err(mem_timeout_err),
        .stall_count(stall_count)
    );

    pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(16), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_reg_write_enable(ex_reg_write_enable), .ex_rd(ex_rd),
        .id_branch_taken(id_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_hold(s_pc_hold), .if_hold(s_if_hold), .id_bubble(s_id_bubble), .if_flush(s_if_flush),
        .ex_hold(s_ex_hold), .mem_hold(s_mem_hold), .mem_timeout_err(s_err),
        .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control outputs packed as {pc_hold, if_hold, id_bubble, if_flush, ex_hold, mem_hold}.
    function automatic logic [31:0] ctl();
        return {26'd0, pc_hold, if_hold, id_bubble, if_flush, ex_hold, mem_hold};
    endfunction

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        ex_valid = 0; ex_mem_read = 0; ex_reg_write_enable = 0; ex_rd = 0;
        id_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rs, input logic [4:0] rt,
                                input logic rs_u, input logic rt_u, input logic [4:0] rd);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rs_used = rs_u; id_rt_used = rt_u;
        ex_valid = 1; ex_mem_read = 1; ex_reg_write_enable = 1; ex_rd = rd;
    endtask

    // Advance one clock; inputs are then changed and outputs sampled mid-low-phase.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        mem_req = 1;
        @(negedge clk);
        #1;
        check("reset_ctl_forced_zero", ctl(), 32'h0);
        step();
        #1;
        check("reset_count", stall_count, 0);
        check("reset_err", mem_timeout_err, 0);
        rst_n = 1;
        idle();
        #1;
        check("idle_ctl", ctl(), 32'h0);

        // Load-use on rs: one-cycle bubble
        set_load_use(5'd8, 5'd0, 1, 0, 5'd8);
        #1;
        check("load_use_ctl", ctl(), 32'b111000);
        step();
        ex_valid = 0;
        #1;
        check("load_use_resolved", ctl(), 32'h0);
        check("load_use_count", stall_count, 1);

        // Non-hazards: rd=0, and rt match with rt unused
        set_load_use(5'd0, 5'd0, 1, 1, 5'd0);
        #1;
        check("rd_zero_no_stall", ctl(), 32'h0);
        set_load_use(5'd3, 5'd8, 1, 0, 5'd8);
        #1;
        check("rt_unused_no_stall", ctl(), 32'h0);
        set_load_use(5'd3, 5'd8, 1, 1, 5'd8);
        #1;
        check("rt_used_stall", ctl(), 32'b111000);
        step();

        // Branch alone flushes; with load-use the bubble wins
        idle();
        id_branch_taken = 1;
        #1;
        check("branch_flush", ctl(), 32'b000100);
        set_load_use(5'd8, 5'd0, 1, 0, 5'd8);
        #1;
        check("branch_with_load_use", ctl(), 32'b111000);
        step();
        idle();
        #1;
        check("count_after_hazards", stall_count, 3);

        // Memory wait: ready low three cycles, then high
        do_reset();
        mem_req = 1;
        mem_ready = 1;
        #1;
        check("mem_ready_same_cycle", ctl(), 32'h0);
        mem_ready = 0;
        id_branch_taken = 1;
        #1;
        check("mem_stall_run", ctl(), 32'b110011);
        for (int i = 0; i < 2; i++) begin
            step();
            check("mem_wait_hold", ctl(), 32'b110011);
        end
        step();
        mem_ready = 1;
        #1;
        check("mem_ready_branch_flush", ctl(), 32'b000100);
        step();
        idle();
        #1;
        check("mem_back_to_run", ctl(), 32'h0);
        check("mem_wait_count", stall_count, 3);
        check("mem_wait_no_err", mem_timeout_err, 0);

        // Timeout: ready held low for 20 cycles
        do_reset();
        mem_req = 1;
        mem_ready = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("timeout_hold", ctl(), 32'b110011);
            check("timeout_err_flag", mem_timeout_err, (i >= 16) ? 1 : 0);
            check("timeout_count", stall_count, i);
            check("sat_count", s_stall_count, (i > 15) ? 15 : i);
            step();
        end
        #1;
        check("timeout_count_final", stall_count, 20);
        check("sat_count_final", s_stall_count, 15);
        mem_req = 0;
        mem_ready = 1;
        id_branch_taken = 1;
        #1;
        check("error_sticky_hold", ctl(), 32'b110011);
        check("error_flag_sticky", mem_timeout_err, 1);

        // Reset out of ERROR clears everything
        rst_n = 0;
        #1;
        check("reset_in_error_ctl", ctl(), 32'h0);
        step();
        rst_n = 1;
        idle();
        #1;
        check("post_reset_err", mem_timeout_err, 0);
        check("post_reset_count", stall_count, 0);
        check("post_reset_ctl", ctl(), 32'h0);

        // Reset mid MEM_WAIT leaves no residual holds
        mem_req = 1;
        step();
        step();
        do_reset();
        mem_req = 0;
        #1;
        check("reset_mid_wait_ctl", ctl(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
